// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard/forwarding controller: register index width,
// bypass select codes, the never-forwarded PC index and the scoreboard slot type.
package hazard_ctrl_pkg;

  localparam int REGIDXW = 4;

  typedef logic [REGIDXW-1:0] reg_idx_t;

  localparam reg_idx_t PC_IDX = 4'd15;

  localparam logic [1:0] BYP_RF    = 2'b00;
  localparam logic [1:0] BYP_EXMEM = 2'b01;
  localparam logic [1:0] BYP_MEMWB = 2'b10;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    logic     we;
    logic     ld;
  } slot_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/branch inputs and execute-stage control outputs of hazard_ctrl.
// HAZARD_PERF_EN adds the stall/flush performance counters.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic       dec_valid_in;
  reg_idx_t   dec_rn_in;
  reg_idx_t   dec_rm_in;
  logic       dec_rn_used_in;
  logic       dec_rm_used_in;
  reg_idx_t   dec_rd_in;
  logic       dec_reg_we_in;
  logic       dec_is_load_in;
  logic       branch_taken_in;
  logic [1:0] bypass_rn_sel_out;
  logic [1:0] bypass_rm_sel_out;
  logic       stall_out;
  logic       make_invalid_out;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_count_out;
  logic [31:0] flush_count_out;
`endif

  modport master (
    output dec_valid_in, dec_rn_in, dec_rm_in, dec_rn_used_in, dec_rm_used_in,
           dec_rd_in, dec_reg_we_in, dec_is_load_in, branch_taken_in,
`ifdef HAZARD_PERF_EN
    input  stall_count_out, flush_count_out,
`endif
    input  bypass_rn_sel_out, bypass_rm_sel_out, stall_out, make_invalid_out
  );

  modport slave (
    input  dec_valid_in, dec_rn_in, dec_rm_in, dec_rn_used_in, dec_rm_used_in,
           dec_rd_in, dec_reg_we_in, dec_is_load_in, branch_taken_in,
`ifdef HAZARD_PERF_EN
    output stall_count_out, flush_count_out,
`endif
    output bypass_rn_sel_out, bypass_rm_sel_out, stall_out, make_invalid_out
  );

endinterface

// File: rtl/hazard_ctrl_slot.sv
// One scoreboard slot {valid, rd, we, ld}; advances every cycle, async-cleared.
module hazard_slot
  import hazard_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  slot_t d,
  output slot_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/forwarding controller: EX/MEM/WB scoreboard, bypass selects,
// load-use stall and post-branch squash. HAZARD_PERF_EN adds perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave hz
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

  slot_t      ex_q, mem_q, wb_q, ex_d;
  logic [1:0] flush_cnt;
  logic       squash, load_use, stall;
  logic       m_ex_rn, m_ex_rm, m_mem_rn, m_mem_rm;
  logic       unused_wb;

  function automatic logic match(input slot_t s, input reg_idx_t src, input logic used);
    return s.valid & s.we & used & (s.rd == src) & (src != PC_IDX);
  endfunction

  // A matching load in EX has no result yet, so it falls through to the MEM check.
  function automatic logic [1:0] select(input logic m_ex, input logic ex_ld, input logic m_mem);
    if (m_ex && !ex_ld) return BYP_EXMEM;
    else if (m_mem)     return BYP_MEMWB;
    else                return BYP_RF;
  endfunction

  assign m_ex_rn  = match(ex_q,  hz.dec_rn_in, hz.dec_rn_used_in);
  assign m_ex_rm  = match(ex_q,  hz.dec_rm_in, hz.dec_rm_used_in);
  assign m_mem_rn = match(mem_q, hz.dec_rn_in, hz.dec_rn_used_in);
  assign m_mem_rm = match(mem_q, hz.dec_rm_in, hz.dec_rm_used_in);

  assign squash   = (flush_cnt != 2'd0) | hz.branch_taken_in;
  assign load_use = ex_q.ld & (m_ex_rn | m_ex_rm);
  assign stall    = load_use & ~squash;

  assign hz.bypass_rn_sel_out = select(m_ex_rn, ex_q.ld, m_mem_rn);
  assign hz.bypass_rm_sel_out = select(m_ex_rm, ex_q.ld, m_mem_rm);
  assign hz.stall_out         = stall;
  assign hz.make_invalid_out  = squash;

  always_comb begin
    ex_d = '0;
    if (!squash && !stall && hz.dec_valid_in)
      ex_d = '{valid: 1'b1, rd: hz.dec_rd_in, we: hz.dec_reg_we_in, ld: hz.dec_is_load_in};
  end

  hazard_slot u_ex  (.clk(clk), .rst_n(rst_n), .d(ex_d),  .q(ex_q));
  hazard_slot u_mem (.clk(clk), .rst_n(rst_n), .d(ex_q),  .q(mem_q));
  hazard_slot u_wb  (.clk(clk), .rst_n(rst_n), .d(mem_q), .q(wb_q));

  // WB is tracked but never forwarded: the register file is write-first.
  assign unused_wb = ^wb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  flush_cnt <= 2'd0;
    else if (hz.branch_taken_in) flush_cnt <= FLUSH_LOAD;
    else if (flush_cnt != 2'd0)  flush_cnt <= flush_cnt - 2'd1;
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_count, flush_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall)              stall_count <= stall_count + 32'd1;
      if (hz.branch_taken_in) flush_count <= flush_count + 32'd1;
    end
  end

  assign hz.stall_count_out = stall_count;
  assign hz.flush_count_out = flush_count;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and forwarding controller.
- Produces the control inputs that the execute stage consumes: the Rm/Rn bypass selects, the pipeline stall, and the make-invalid (squash) signal.
- Keeps a 3-slot scoreboard of in-flight destination registers (EX, MEM, WB).
- Detects load-use hazards and squashes the two younger instructions after a taken branch.

Parameters:
- REGIDXW, 4, register index width (16 architectural registers).
- FLUSH_CYCLES, 2, cycles of make_invalid asserted after a taken branch (1..3).
- PC_IDX, 15, register index never forwarded (PC reads come from the fetch path).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dec_valid_in  in  1  decode holds a valid instruction.
- dec_rn_in  in  REGIDXW  Rn source index.
- dec_rm_in  in  REGIDXW  Rm source index.
- dec_rn_used_in  in  1  instruction reads Rn.
- dec_rm_used_in  in  1  instruction reads Rm.
- dec_rd_in  in  REGIDXW  destination index.
- dec_reg_we_in  in  1  instruction writes Rd.
- dec_is_load_in  in  1  instruction is a load; result is available only at MEM.
- branch_taken_in  in  1  EX resolved a taken branch this cycle.
- bypass_rn_sel_out  out  2  00 regfile, 01 EX/MEM ALU result, 10 MEM/WB result.
- bypass_rm_sel_out  out  2  same encoding as bypass_rn_sel_out.
- stall_out  out  1  hold fetch/decode pipeline registers.
- make_invalid_out  out  1  squash the instruction entering EX.

Behaviour:
- Scoreboard slots ex, mem, wb. Each slot holds {valid, rd, we, ld}.
- Reset values:
  - All slots invalid.
  - Flush counter 0.
  - stall_out = 0, make_invalid_out = 0, both bypass selects = 00.
- Reset is asynchronous. Assertion mid-operation clears all state immediately.
- Match(slot, src) = slot.valid & slot.we & used & (slot.rd == src) & (src != PC_IDX).
- Bypass select per operand is combinational from registered slots and decode inputs. Youngest wins:
  - match(ex) & ~ex.ld → 01.
  - else match(mem) → 10.
  - else 00.
  - wb is not forwarded: the regfile is write-first.
- Load-use: match(ex) with ex.ld on either used operand → stall_out = 1 for exactly one cycle.
  - Next cycle the producer is in mem and is forwarded with select 10.
- Slot update each cycle, in priority order:
  - flush active or branch_taken_in: ex ← invalid.
  - else stall_out: ex ← bubble (invalid).
  - else ex ← {dec_valid_in, dec_rd_in, dec_reg_we_in, dec_is_load_in}.
  - Always mem ← ex and wb ← mem. Stall never freezes the downstream slots.
- Flush:
  - branch_taken_in loads the counter with FLUSH_CYCLES.
  - make_invalid_out = (counter != 0) | branch_taken_in.
  - Counter decrements to 0 and saturates there.
- Flush wins over load-use: stall_out is forced 0 while make_invalid_out is 1.
- A branch during an active flush reloads the counter. There is no accumulation.
- The scoreboard ignores decode while dec_valid_in = 0; a bubble enters ex.
- Latency:
  - bypass selects and stall_out: 0 cycles (combinational).
  - slot advance: 1 cycle.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, adds two outputs:
  - stall_count_out, 32-bit: increments each cycle stall_out = 1.
  - flush_count_out, 32-bit: increments on each branch_taken_in.
- Both counters reset to 0, wrap modulo 2^32, and are async-cleared by rst_n.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared defines file gets:
  - REGIDXW.
  - Bypass select codes BYP_RF = 2'b00, BYP_EXMEM = 2'b01, BYP_MEMWB = 2'b10.
  - PC index.
- One sub-module, hazard_slot: a registered {valid, rd, we, ld} with async clear, instantiated three times.
- The match comparators stay in the top level.

Test Plan:
- Reset, then hold dec_valid_in = 0 → all selects 00, stall 0, make_invalid 0.
- Back-to-back ALU instructions: ADD r3 then SUB r4, r3, r5 (Rn = 3) → bypass_rn_sel_out = 01 in the SUB's decode cycle. One bubble gap → 10. Two-bubble gap → 00.
- Load-use: LDR r2 followed by ORR r6, r7, r2 (Rm = 2) → stall_out = 1 for one cycle, then bypass_rm_sel_out = 10, stall 0.
- r15 hazard: ADD r15 followed by a reader of r15 → selects stay 00, no stall.
- Branch: branch_taken_in pulse → make_invalid_out high that cycle plus 2 more (FLUSH_CYCLES = 2), squashed slots never cause a bypass match. A simultaneous load-use condition gives stall_out = 0. A second branch during the flush restarts the count.
- Drive rst_n low mid-flush with ex.ld valid → outputs return to reset values asynchronously. With HAZARD_PERF_EN defined, both counters read 0.
